// File: rtl/fp_adder_align_pipe.sv
// fp_adder_align_pipe
// Two-stage, valid/ready flow-controlled align stage of the FP adder.
// Stage 1 orders the operands by magnitude, applies op_sub to b's sign,
// and computes the clamped exponent difference. Stage 2 right-shifts the
// smaller mantissa by that difference.
// Optional feature macro: FP_ALIGN_STICKY_EN. When it is defined, the bits
// shifted out of the smaller mantissa are ORed into mant_b[0].

`ifndef FP32
`define FP32 0
`endif
`ifndef FP64
`define FP64 1
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) (((f) == `FP64) ? 11 : 8)
`endif
`ifndef GET_MANTISSA_LEN
`define GET_MANTISSA_LEN(f) (((f) == `FP64) ? 52 : 23)
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(f) (((f) == `FP64) ? 64 : 32)
`endif
`ifndef GET_PROTECT_LEN
`define GET_PROTECT_LEN(f) 3
`endif

module fp_adder_align_pipe #(
    parameter int data_format = `FP32,
    parameter int PROTECT_LEN = `GET_PROTECT_LEN(data_format),
    localparam int E  = `GET_EXP_LEN(data_format),
    localparam int M  = `GET_MANTISSA_LEN(data_format),
    localparam int N  = `GET_FP_LEN(data_format),
    localparam int W  = M + PROTECT_LEN + 1,
    localparam int DW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         a_sign,
    output logic         b_sign,
    output logic         eff_sub,
    output logic         swapped,
    output logic [E-1:0] exp,
    output logic [W-1:0] mant_a,
    output logic [W-1:0] mant_b
);

    // Unpacked operand fields.
    logic         sign_a, sign_b;
    logic [E-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [W-1:0] mant_in_a, mant_in_b;
    logic         a_larger;

    assign sign_a    = a[N-1];
    assign sign_b    = b[N-1] ^ op_sub;
    assign exp_a     = a[N-2:M];
    assign exp_b     = b[N-2:M];
    // Denormals use an effective exponent of 1 and a zero hidden bit.
    assign eexp_a    = (exp_a == '0) ? E'(1) : exp_a;
    assign eexp_b    = (exp_b == '0) ? E'(1) : exp_b;
    assign mant_in_a = {exp_a != '0, a[M-1:0], {PROTECT_LEN{1'b0}}};
    assign mant_in_b = {exp_b != '0, b[M-1:0], {PROTECT_LEN{1'b0}}};
    // Comparing the raw exponent/fraction fields gives true magnitude order,
    // including the denormal vs. smallest-normal case (exponents 0 and 1
    // share an effective exponent, but only the normal has a hidden bit).
    assign a_larger  = (a[N-2:0] >= b[N-2:0]);

    // Stage 1 combinational results.
    logic [E-1:0]  large_exp, small_exp, exp_diff;
    logic [W-1:0]  large_mant, small_mant;
    logic [DW-1:0] shift_d;

    // Select the larger/smaller operand and clamp the shift distance to W.
    always_comb begin
        large_exp  = a_larger ? eexp_a    : eexp_b;
        small_exp  = a_larger ? eexp_b    : eexp_a;
        large_mant = a_larger ? mant_in_a : mant_in_b;
        small_mant = a_larger ? mant_in_b : mant_in_a;
        exp_diff   = large_exp - small_exp;
        shift_d    = (exp_diff >= E'(W)) ? DW'(W) : DW'(exp_diff);
    end

    // Handshake: each stage loads when it is empty or the stage after it drains.
    logic v1, v2;
    logic s1_load, s2_load;

    assign s2_load   = !v2 || out_ready;
    assign s1_load   = !v1 || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = v2;

    // Stage 1 registers.
    logic          s1_a_sign, s1_b_sign, s1_swapped;
    logic [E-1:0]  s1_exp;
    logic [W-1:0]  s1_mant_a, s1_small;
    logic [DW-1:0] s1_d;

    // Stage 1: capture ordered operands on every input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset alongside the valid bits so the
        // outputs read a defined zero before the first transfer.
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_a_sign  <= 1'b0;
            s1_b_sign  <= 1'b0;
            s1_swapped <= 1'b0;
            s1_exp     <= '0;
            s1_mant_a  <= '0;
            s1_small   <= '0;
            s1_d       <= '0;
        end else if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_a_sign  <= a_larger ? sign_a : sign_b;
                s1_b_sign  <= a_larger ? sign_b : sign_a;
                s1_swapped <= !a_larger;
                s1_exp     <= large_exp;
                s1_mant_a  <= large_mant;
                s1_small   <= small_mant;
                s1_d       <= shift_d;
            end
        end
    end

    // Stage 2 combinational shift of the smaller mantissa.
    logic [W-1:0] small_shift;

`ifdef FP_ALIGN_STICKY_EN
    logic [W-1:0] lost_mask;

    // Shift right and fold every discarded bit into the sticky LSB.
    always_comb begin
        lost_mask   = ~({W{1'b1}} << s1_d);
        small_shift = (s1_small >> s1_d)
                    | {{(W-1){1'b0}}, |(s1_small & lost_mask)};
    end
`else
    // Shift right and truncate the discarded bits.
    always_comb begin
        small_shift = s1_small >> s1_d;
    end
`endif

    // Stage 2: output registers; they hold while stalled or empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            a_sign  <= 1'b0;
            b_sign  <= 1'b0;
            eff_sub <= 1'b0;
            swapped <= 1'b0;
            exp     <= '0;
            mant_a  <= '0;
            mant_b  <= '0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                a_sign  <= s1_a_sign;
                b_sign  <= s1_b_sign;
                eff_sub <= s1_a_sign ^ s1_b_sign;
                swapped <= s1_swapped;
                exp     <= s1_exp;
                mant_a  <= s1_mant_a;
                mant_b  <= small_shift;
            end
        end
    end

endmodule

// File: tb/tb_fp_adder_align_pipe.sv
// Testbench for fp_adder_align_pipe (FP32, PROTECT_LEN=3, W=27).
// Expected mant_b depends on whether FP_ALIGN_STICKY_EN is defined.

module tb_fp_adder_align_pipe;

    typedef struct packed {
        logic        a_sign;
        logic        b_sign;
        logic        eff_sub;
        logic        swapped;
        logic [7:0]  ex;
        logic [26:0] mant_a;
        logic [26:0] mant_b;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        exp_res;
    } vec_t;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        a_sign, b_sign, eff_sub, swapped;
    logic [7:0]  exp;
    logic [26:0] mant_a, mant_b;

    int n_cmp = 0;
    int n_bad = 0;
    res_t q[$];

    fp_adder_align_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .eff_sub   (eff_sub),
        .swapped   (swapped),
        .exp       (exp),
        .mant_a    (mant_a),
        .mant_b    (mant_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic res_t actual();
        return {a_sign, b_sign, eff_sub, swapped, exp, mant_a, mant_b};
    endfunction

    // Reference: plain integer arithmetic on the IEEE fields.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        res_t r;
        longint ex_x, ex_y, fr_x, fr_y, m_x, m_y, el, es, ml, ms, d, scale;
        bit sx, sy, x_big;
        sx   = x[31];
        sy   = y[31] ^ sub;
        ex_x = longint'(x[30:23]);
        ex_y = longint'(y[30:23]);
        fr_x = longint'(x[22:0]);
        fr_y = longint'(y[22:0]);
        m_x  = ((ex_x != 0 ? 64'd8388608 : 64'd0) + fr_x) * 8;
        m_y  = ((ex_y != 0 ? 64'd8388608 : 64'd0) + fr_y) * 8;
        if (ex_x == 0) ex_x = 1;
        if (ex_y == 0) ex_y = 1;
        x_big = (ex_x > ex_y) || (ex_x == ex_y && m_x >= m_y);
        el = x_big ? ex_x : ex_y;
        es = x_big ? ex_y : ex_x;
        ml = x_big ? m_x : m_y;
        ms = x_big ? m_y : m_x;
        d  = el - es;
        if (d > 27) d = 27;
        scale = 64'd1 << d;
        r.a_sign  = x_big ? sx : sy;
        r.b_sign  = x_big ? sy : sx;
        r.eff_sub = sx ^ sy;
        r.swapped = !x_big;
        r.ex      = el[7:0];
        r.mant_a  = ml[26:0];
        r.mant_b  = 27'(ms / scale);
        if (STICKY && (ms % scale) != 0) r.mant_b[0] = 1'b1;
        return r;
    endfunction

    // One clock: check the visible output, drive new inputs, record transfers.
    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic ordy, output logic acc);
        @(negedge clk);
        if (out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_extra: got out_valid=1 expected no pending result");
            end else begin
                check("stream_data", 128'(actual()), 128'(q[0]));
            end
        end
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op_sub    = isub;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model(ia, ib, isub));
    endtask

    function automatic logic [31:0] rand_op(input logic [7:0] base);
        int sel;
        logic [7:0] e;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'd255;
        else               e = base + 8'($urandom_range(0, 31)) - 8'd16;
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    vec_t vecs[7];

    initial begin
        logic acc;
        int   n_acc, idx;
        logic [31:0] sa[4];
        logic [31:0] ra, rb;

        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 27'h4000000, 27'h2000000}};
        vecs[1] = '{32'h4B800000, 32'h3F800001, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h97, 27'h4000000, STICKY ? 27'h5 : 27'h4}};
        vecs[2] = '{32'h7E800000, 32'h3F800000, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFD, 27'h4000000, STICKY ? 27'h1 : 27'h0}};
        vecs[3] = '{32'h00000001, 32'h00800000, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 27'h4000000, 27'h0000008}};
        vecs[4] = '{32'h40400000, 32'h40400000, 1'b1, '{1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 27'h6000000, 27'h6000000}};
        vecs[5] = '{32'hC0000000, 32'h3F800000, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000}};
        vecs[6] = '{32'h4D000000, 32'h3F800000, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 27'h4000000, STICKY ? 27'h1 : 27'h0}};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_outputs", 128'(actual()), 128'(0));
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 128'(in_ready), 128'(1));

        // Directed vectors, one at a time, with latency checks.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; op_sub = vecs[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(1));
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_latency1", i), 128'(out_valid), 128'(0));
            @(negedge clk);
            check($sformatf("vec%0d_latency2", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d_result", i), 128'(actual()), 128'(vecs[i].exp_res));
        end
        @(negedge clk);
        check("empty_out_valid", 128'(out_valid), 128'(0));
        check("empty_hold", 128'(actual()), 128'(vecs[6].exp_res));

        // Backpressure: four back-to-back inputs with the output stalled 3 cycles.
        for (int i = 0; i < 4; i++) sa[i] = {1'b0, 8'(8'd120 + i * 3), 23'(i * 12345 + 7)};
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, sa[idx], sa[3 - idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("full_accepted", 128'(idx), 128'(2));
        check("full_in_ready", 128'(in_ready), 128'(0));
        for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
            cycle(idx < 4, sa[idx & 3], sa[3 - (idx & 3)], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_drained", 128'(q.size()), 128'(0));
        check("bp_all_accepted", 128'(idx), 128'(4));

        // Randomized stream with random valid/ready.
        n_acc = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] base;
            base = 8'($urandom_range(1, 254));
            ra = rand_op(base);
            rb = ($urandom_range(0, 15) == 0) ? ra : rand_op(base);
            cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 9) < 7, acc);
            if (acc) n_acc++;
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("rand_drained", 128'(q.size()), 128'(0));
        check("rand_activity", 128'(n_acc > 500), 128'(1));

        // Mid-flight reset discards both stages.
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h40400000, 32'h3F800000, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_out_valid", 128'(out_valid), 128'(0));
        check("midreset_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_empty", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
